rom_port_arbiter: RTL and testbench



---
 rtl/rom_port_arbiter.sv | 93 +++++++++
 tb/tb_rom_port_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the instruction ROM read port between the fetch
// port (F) and the data/literal port (D). Round-robin grant with a per-port
// registered response and valid/ready backpressure. Also counts the cycles in
// which both ports were eligible.
module rom_port_arbiter #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              f_rready,
  // data port
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              d_rready,
  // ROM side
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst,
  // statistics
  output logic [CNT_W-1:0]  conflict_cnt
);

  // 1 when D holds the most recent grant, so F wins the next conflict
  logic last_gnt_d;
  logic elig_f;
  logic elig_d;
  logic both_elig;

  // Eligibility: a full, undrained response register blocks its port
  always_comb begin
    elig_f    = f_req && (!f_rvalid || f_rready);
    elig_d    = d_req && (!d_rvalid || d_rready);
    both_elig = elig_f && elig_d;
  end

  // Round-robin grant; never depends on rom_inst, suppressed during reset
  always_comb begin
    f_gnt    = 1'b0;
    d_gnt    = 1'b0;
    if (!rst) begin
      f_gnt = elig_f && (!elig_d || last_gnt_d);
      d_gnt = elig_d && (!elig_f || !last_gnt_d);
    end
    rom_addr = d_gnt ? d_addr : f_addr;
  end

  // Response registers, grant history and saturating conflict counter
  always_ff @(posedge clk) begin
    if (rst) begin
      f_rvalid     <= 1'b0;
      f_rdata      <= '0;
      d_rvalid     <= 1'b0;
      d_rdata      <= '0;
      last_gnt_d   <= 1'b1;
      conflict_cnt <= '0;
    end else begin
      if (f_gnt) begin
        f_rdata  <= rom_inst;
        f_rvalid <= 1'b1;
      end else if (f_rready) begin
        f_rvalid <= 1'b0;
      end

      if (d_gnt) begin
        d_rdata  <= rom_inst;
        d_rvalid <= 1'b1;
      end else if (d_rready) begin
        d_rvalid <= 1'b0;
      end

      if (f_gnt) begin
        last_gnt_d <= 1'b0;
      end else if (d_gnt) begin
        last_gnt_d <= 1'b1;
      end

      if (both_elig && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed testbench for rom_port_arbiter with a behavioural combinational ROM.
module tb_rom_port_arbiter;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              f_req, d_req;
  logic [ADDR_W-1:0] f_addr, d_addr;
  logic              f_gnt, d_gnt;
  logic              f_rvalid, d_rvalid;
  logic [DATA_W-1:0] f_rdata, d_rdata;
  logic              f_rready, d_rready;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;
  logic [CNT_W-1:0]  conflict_cnt;

  int npass;
  int ntotal;

  rom_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_rready(f_rready),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_rready(d_rready),
    .rom_addr(rom_addr), .rom_inst(rom_inst), .conflict_cnt(conflict_cnt)
  );

  // ROM contents: word 5 is addi x1,x0,5; every other word is tagged with its address
  function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(5)) return 32'h0050_0093;
    return 32'hC0DE_0000 | DATA_W'(a);
  endfunction

  assign rom_inst = rom(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    npass  = 0;
    ntotal = 0;
    rst = 1'b1;
    f_req = 1'b0; d_req = 1'b0;
    f_addr = '0;  d_addr = '0;
    f_rready = 1'b1; d_rready = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_f_rdata", f_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);

    // F alone
    rst = 1'b0;
    f_req = 1'b1; f_addr = 11'h005;
    #1;
    chk("f_alone_gnt", 32'(f_gnt), 32'd1);
    chk("f_alone_dgnt", 32'(d_gnt), 32'd0);
    chk("f_alone_romaddr", 32'(rom_addr), 32'h005);
    tick();
    f_req = 1'b0;
    chk("f_alone_rvalid", 32'(f_rvalid), 32'd1);
    chk("f_alone_rdata", f_rdata, 32'h0050_0093);
    chk("f_alone_d_rvalid", 32'(d_rvalid), 32'd0);
    tick();
    chk("f_alone_drained", 32'(f_rvalid), 32'd0);

    // Streaming F, one grant per cycle
    f_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f_addr = ADDR_W'(i);
      #1;
      chk($sformatf("stream_gnt%0d", i), 32'(f_gnt), 32'd1);
      tick();
      chk($sformatf("stream_rvalid%0d", i), 32'(f_rvalid), 32'd1);
      chk($sformatf("stream_rdata%0d", i), f_rdata, rom(ADDR_W'(i)));
    end
    f_req = 1'b0;
    tick();

    // Conflict from reset: F, D, F, D
    rst = 1'b1;
    tick();
    rst = 1'b0;
    f_req = 1'b1; f_addr = 11'h010;
    d_req = 1'b1; d_addr = 11'h7FF;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("conf_fgnt%0d", k), 32'(f_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("conf_dgnt%0d", k), 32'(d_gnt), (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("conf_cnt%0d", k), 32'(conflict_cnt), 32'(k + 1));
      if (k % 2 == 0) chk($sformatf("conf_frdata%0d", k), f_rdata, rom(11'h010));
      else            chk($sformatf("conf_drdata%0d", k), d_rdata, 32'hC0DE_07FF);
    end
    f_req = 1'b0; d_req = 1'b0;
    tick(); tick();

    // Backpressure on F: D gets every cycle, F data frozen
    f_req = 1'b1; f_addr = 11'h020;
    #1;
    chk("bp_fill_gnt", 32'(f_gnt), 32'd1);
    tick();
    chk("bp_fill_rdata", f_rdata, rom(11'h020));
    f_rready = 1'b0; f_addr = 11'h021;
    d_req = 1'b1; d_addr = 11'h030;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_fgnt%0d", k), 32'(f_gnt), 32'd0);
      chk($sformatf("bp_dgnt%0d", k), 32'(d_gnt), 32'd1);
      tick();
      chk($sformatf("bp_frvalid%0d", k), 32'(f_rvalid), 32'd1);
      chk($sformatf("bp_frdata%0d", k), f_rdata, rom(11'h020));
      chk($sformatf("bp_drdata%0d", k), d_rdata, rom(11'h030));
    end
    chk("bp_cnt_hold", 32'(conflict_cnt), 32'd4);
    f_rready = 1'b1;
    #1;
    chk("bp_release_fgnt", 32'(f_gnt), 32'd1);
    chk("bp_release_dgnt", 32'(d_gnt), 32'd0);
    tick();
    chk("bp_release_rvalid", 32'(f_rvalid), 32'd1);
    chk("bp_release_rdata", f_rdata, rom(11'h021));
    chk("bp_release_cnt", 32'(conflict_cnt), 32'd5);
    f_req = 1'b0; d_req = 1'b0;
    tick(); tick();

    // Reset mid-flight, the cycle after a D grant
    d_req = 1'b1; d_addr = 11'h040;
    #1;
    chk("mid_dgnt", 32'(d_gnt), 32'd1);
    tick();
    rst = 1'b1; f_req = 1'b1; f_addr = 11'h050;
    #1;
    chk("mid_rst_fgnt", 32'(f_gnt), 32'd0);
    chk("mid_rst_dgnt", 32'(d_gnt), 32'd0);
    tick();
    chk("mid_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("mid_f_rvalid", 32'(f_rvalid), 32'd0);
    chk("mid_cnt", 32'(conflict_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_first_fgnt", 32'(f_gnt), 32'd1);
    chk("mid_first_dgnt", 32'(d_gnt), 32'd0);
    f_req = 1'b0; d_req = 1'b0;
    tick(); tick();

    // Last F grant before reset must not carry over: F still wins after reset
    f_req = 1'b1; f_addr = 11'h060;
    tick();
    f_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    f_req = 1'b1; d_req = 1'b1;
    #1;
    chk("lastgnt_rst_fgnt", 32'(f_gnt), 32'd1);
    chk("lastgnt_rst_dgnt", 32'(d_gnt), 32'd0);

    // Saturation: 2^CNT_W + 3 conflict cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat ((1 << CNT_W) + 3) tick();
    chk("sat_cnt", 32'(conflict_cnt), 32'h0000_FFFF);
    tick();
    chk("sat_cnt_hold", 32'(conflict_cnt), 32'h0000_FFFF);
    f_req = 1'b0; d_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
